// File: rtl/adder_sub_1bit_cell.sv
// One-bit full adder / subtractor slice with a combinational result and an
// enable-gated registered copy for pipelined ripple datapaths.
module adder_sub_1bit_cell (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic sel,
    input  logic Cin,
    input  logic en,
    output logic sum,
    output logic Cout,
    output logic sum_q,
    output logic Cout_q,
    output logic valid_q
);

    logic w_bx;
    logic w_prop;
    logic w_sum;
    logic w_cout;

    logic r_sum;
    logic r_cout;
    logic r_valid;

    // Subtract is a + ~b + Cin; Cout=1 then means "no borrow".
    assign w_bx   = b ^ sel;
    assign w_prop = a ^ w_bx;
    assign w_sum  = w_prop ^ Cin;
    assign w_cout = (a & w_bx) | (Cin & w_prop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= 1'b0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_sum   <= w_sum;
            r_cout  <= w_cout;
            r_valid <= 1'b1;
        end
    end

    assign sum     = w_sum;
    assign Cout    = w_cout;
    assign sum_q   = r_sum;
    assign Cout_q  = r_cout;
    assign valid_q = r_valid;

endmodule

// File: tb/tb_adder_sub_1bit_cell.sv
// Scoreboard bench for adder_sub_1bit_cell: combinational sweeps, register path,
// hold, reset priority, streaming captures and a 4-slice ripple chain.
module tb_adder_sub_1bit_cell;

    logic clk = 1'b0;
    logic rst, a, b, sel, Cin, en;
    logic sum, Cout, sum_q, Cout_q, valid_q;

    always #5 clk = ~clk;

    adder_sub_1bit_cell dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .sel     (sel),
        .Cin     (Cin),
        .en      (en),
        .sum     (sum),
        .Cout    (Cout),
        .sum_q   (sum_q),
        .Cout_q  (Cout_q),
        .valid_q (valid_q)
    );

    // Four-slice ripple chain
    logic [3:0] ch_a, ch_b, ch_sum, ch_sq, ch_cq, ch_vq;
    logic [4:0] ch_c;
    logic       ch_sel;
    assign ch_c[0] = 1'b1;

    for (genvar g = 0; g < 4; g++) begin : g_chain
        adder_sub_1bit_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .a       (ch_a[g]),
            .b       (ch_b[g]),
            .sel     (ch_sel),
            .Cin     (ch_c[g]),
            .en      (1'b0),
            .sum     (ch_sum[g]),
            .Cout    (ch_c[g+1]),
            .sum_q   (ch_sq[g]),
            .Cout_q  (ch_cq[g]),
            .valid_q (ch_vq[g])
        );
    end

    typedef struct {
        logic [2:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [1:0] model(input logic ma, input logic mb, input logic ms,
                                         input logic mc);
        logic [1:0] r;
        r = 2'(ma) + 2'(mb ^ ms) + 2'(mc);
        return r;
    endfunction

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; sel = 1'b0; Cin = 1'b0;
        exp_q.push_back('{3'b000, "reset"});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({valid_q, Cout_q, sum_q} !== e.val) begin
            errors++;
            $display("FAIL %s: got v/c/s=%b%b%b required %b", e.name, valid_q, Cout_q, sum_q,
                     e.val);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic comb_sweep(input logic s, input string nm);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            sel = s;
            {a, b, Cin} = 3'(i);
            exp_q.push_back('{{1'b0, model(a, b, s, Cin)}, $sformatf("%s_%0d", nm, i)});
            #50;
            e = exp_q.pop_front();
            checks++;
            if ({Cout, sum} !== e.val[1:0]) begin
                errors++;
                $display("FAIL %s: got Cout/sum=%b%b required %b", e.name, Cout, sum, e.val[1:0]);
            end
        end
    endtask

    task automatic test_add();
        comb_sweep(1'b0, "add");
    endtask

    task automatic test_sub();
        comb_sweep(1'b1, "sub");
    endtask

    task automatic check_regs();
        exp_t e;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({valid_q, Cout_q, sum_q} !== e.val) begin
            errors++;
            $display("FAIL %s: got v/c/s=%b%b%b required %b", e.name, valid_q, Cout_q, sum_q,
                     e.val);
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        exp_q.push_back('{3'b000, "reg_rst"});
        check_regs();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; sel = 1'b0; a = 1'b1; b = 1'b1; Cin = 1'b0;
        exp_q.push_back('{3'b110, "reg_capture"});
        check_regs();
    endtask

    task automatic test_hold();
        @(negedge clk);
        en = 1'b0; a = 1'b0; b = 1'b0; Cin = 1'b1;
        #1;
        checks++;
        if ({Cout, sum} !== 2'b01) begin
            errors++;
            $display("FAIL hold_comb: got Cout/sum=%b%b required 01", Cout, sum);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{3'b110, $sformatf("hold_%0d", i)});
            check_regs();
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; sel = 1'b0; a = 1'b1; b = 1'b0; Cin = 1'b0;
        exp_q.push_back('{3'b000, "rstprio_regs"});
        check_regs();
        checks++;
        if ({Cout, sum} !== 2'b01) begin
            errors++;
            $display("FAIL rstprio_comb: got Cout/sum=%b%b required 01", Cout, sum);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{3'b101, "rstprio_release"});
        check_regs();
    endtask

    task automatic test_back_to_back();
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            {a, b, sel, Cin} = 4'($urandom_range(0, 15));
            exp_q.push_back('{{1'b1, model(a, b, sel, Cin)}, $sformatf("b2b_%0d", i)});
            check_regs();
        end
        en = 1'b0;
    endtask

    task automatic chain_case(input logic [3:0] va, input logic [3:0] vb,
                              input logic [4:0] want, input string nm);
        ch_sel = 1'b1; ch_a = va; ch_b = vb;
        #1;
        checks++;
        if ({ch_c[4], ch_sum} !== want) begin
            errors++;
            $display("FAIL %s: got Cout=%b result=%0d required Cout=%b result=%0d", nm, ch_c[4],
                     ch_sum, want[4], want[3:0]);
        end
    endtask

    task automatic test_chain();
        chain_case(4'd5, 4'd3, {1'b1, 4'd2}, "chain_5m3");
        chain_case(4'd3, 4'd5, {1'b0, 4'hE}, "chain_3m5");
        chain_case(4'd9, 4'd9, {1'b1, 4'd0}, "chain_9m9");
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; sel = 1'b0; Cin = 1'b0;
        ch_a = '0; ch_b = '0; ch_sel = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_register();
        test_hold();
        test_reset_priority();
        test_back_to_back();
        test_chain();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
